bus_driver_ctrl: RTL and testbench



---
 rtl/bus_pkg.sv | 17 +
 rtl/sync_fifo.sv | 63 ++++++
 rtl/bus_driver_ctrl.sv | 105 ++++++++++
 tb/tb_bus_driver_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared defaults and FSM state encoding for the bus driver controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_pkg;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_DEPTH     = 4;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRIVE = 2'd2,
        TURN  = 2'd3
    } bus_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with fall-through head (dout) and second-entry peek (dout_nxt).
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens in the same cycle.
module sync_fifo
    import bus_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [WIDTH-1:0]         dout_nxt,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_nxt;
    logic [CW-1:0]    count_q;
    logic             push_acc;
    logic             pop_acc;

    assign full       = (count_q == CW'(DEPTH));
    assign empty      = (count_q == '0);
    assign count      = count_q;
    // A pop frees the slot the push lands in, so a full FIFO still accepts it.
    assign push_acc   = push && (!full || pop);
    assign pop_acc    = pop && !empty;
    assign rd_ptr_nxt = rd_ptr_q + AW'(1);
    assign dout       = mem_q[rd_ptr_q];
    assign dout_nxt   = mem_q[rd_ptr_nxt];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_acc) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_acc)  rd_ptr_q <= rd_ptr_nxt;
            case ({push_acc, pop_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/bus_driver_ctrl.sv
// Buffers words and drives them onto a shared bus via a tri-state enable, in bursts of up to MAX_BURST.
// Latency: word written into an empty FIFO in IDLE reaches bus_data with s=1 three cycles later (immediate gnt).
// Backpressure: full flags a full FIFO; writes while full are dropped unless the bus pops that cycle.
module bus_driver_ctrl
    import bus_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int MAX_BURST = DEF_MAX_BURST
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output logic                   req,
    input  logic                   gnt,
    output logic                   s,
    output logic [WIDTH-1:0]       bus_data
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    bus_state_e       state_q, state_d;
    logic [BW-1:0]    burst_q, burst_d;
    logic             s_q, s_d;
    logic             req_q, req_d;
    logic [WIDTH-1:0] bus_data_q, bus_data_d;
    logic             pop;
    logic [WIDTH-1:0] fifo_dout;
    logic [WIDTH-1:0] fifo_dout_nxt;
    logic             last_burst;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (wr_en),
        .pop      (pop),
        .din      (wr_data),
        .dout     (fifo_dout),
        .dout_nxt (fifo_dout_nxt),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign last_burst = (burst_q == BW'(MAX_BURST - 1));

    always_comb begin
        state_d = state_q;
        burst_d = '0;
        pop     = 1'b0;
        case (state_q)
            IDLE:  if (count != '0) state_d = REQ;
            REQ:   if (gnt) state_d = DRIVE;
            DRIVE: begin
                // The word on the bus this cycle is the FIFO head; it leaves at the next edge.
                pop     = 1'b1;
                burst_d = burst_q + BW'(1);
                if (last_burst || (count == CW'(1) && !wr_en)) state_d = TURN;
            end
            TURN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so bus_data must carry the head as it will be after this edge.
    always_comb begin
        s_d        = (state_d == DRIVE);
        req_d      = (state_d == REQ) || (state_d == DRIVE);
        bus_data_d = bus_data_q;
        if (state_d == DRIVE) begin
            if (state_q != DRIVE)       bus_data_d = fifo_dout;
            else if (count > CW'(1))    bus_data_d = fifo_dout_nxt;
            else                        bus_data_d = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            burst_q    <= '0;
            s_q        <= 1'b0;
            req_q      <= 1'b0;
            bus_data_q <= '0;
        end else begin
            state_q    <= state_d;
            burst_q    <= burst_d;
            s_q        <= s_d;
            req_q      <= req_d;
            bus_data_q <= bus_data_d;
        end
    end

    assign s        = s_q;
    assign req      = req_q;
    assign bus_data = bus_data_q;

endmodule

// File: tb/tb_bus_driver_ctrl.sv
// Scoreboard bench for bus_driver_ctrl: expected bus words are queued at write time, a monitor pops them on s=1.
module tb_bus_driver_ctrl;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       req;
    logic       gnt;
    logic       s;
    logic [7:0] bus_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int runs[$];
    int run_len = 0;

    bus_driver_ctrl #(.WIDTH(8), .DEPTH(4), .MAX_BURST(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .req      (req),
        .gnt      (gnt),
        .s        (s),
        .bus_data (bus_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle with s=1 must match the next expected word.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len = 0;
        end else if (s) begin
            run_len++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_drive: got bus_data 0x%0h, expected no drive", bus_data);
            end else begin
                chk("bus_word", {24'h0, bus_data}, {24'h0, exp_q.pop_front()});
            end
        end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && !req && !s) && n < 100) begin
            step();
            n++;
        end
        chk({name, "_drain_timeout"}, {31'h0, (n < 100)}, 32'h1);
        repeat (2) step();
    endtask

    initial begin
        rst_n   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        gnt     = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_s", {31'h0, s}, 32'h0);
        chk("rst_req", {31'h0, req}, 32'h0);
        chk("rst_bus_data", {24'h0, bus_data}, 32'h0);
        chk("rst_count", {29'h0, count}, 32'h0);
        chk("rst_empty", {31'h0, empty}, 32'h1);
        chk("rst_full", {31'h0, full}, 32'h0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Single word with grant tied high.
        gnt = 1'b1;
        exp_q.push_back(8'h04);
        wr(8'h04);
        chk("single_count", {29'h0, count}, 32'h1);
        chk("single_req_idle", {31'h0, req}, 32'h0);
        step();
        chk("single_req", {31'h0, req}, 32'h1);
        chk("single_s_in_req", {31'h0, s}, 32'h0);
        step();
        chk("single_s_drive", {31'h0, s}, 32'h1);
        step();
        chk("single_s_turn", {31'h0, s}, 32'h0);
        chk("single_req_turn", {31'h0, req}, 32'h0);
        chk("single_hold", {24'h0, bus_data}, 32'h04);
        chk("single_empty", {31'h0, empty}, 32'h1);
        wait_idle("single");

        // Burst limit: six words split into tenures of 4 and 2.
        runs.delete();
        for (int i = 1; i <= 6; i++) begin
            exp_q.push_back(8'(i));
            wr(8'(i));
        end
        wait_idle("burst");
        chk("burst_tenures", runs.size(), 32'd2);
        if (runs.size() == 2) begin
            chk("burst_first_len", runs[0], 32'd4);
            chk("burst_second_len", runs[1], 32'd2);
        end

        // Grant delayed for ten cycles.
        gnt = 1'b0;
        exp_q.push_back(8'h05);
        wr(8'h05);
        step();
        for (int i = 0; i < 10; i++) begin
            chk("gdelay_req", {31'h0, req}, 32'h1);
            chk("gdelay_s", {31'h0, s}, 32'h0);
            step();
        end
        gnt = 1'b1;
        step();
        chk("gdelay_s_after_gnt", {31'h0, s}, 32'h1);
        chk("gdelay_data", {24'h0, bus_data}, 32'h05);
        wait_idle("gdelay");

        // Overflow: fifth write while full is dropped.
        gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(8'hA0 + 8'(i));
            wr(8'hA0 + 8'(i));
        end
        chk("ovf_full", {31'h0, full}, 32'h1);
        chk("ovf_count4", {29'h0, count}, 32'h4);
        wr(8'hA4);
        chk("ovf_count_after_drop", {29'h0, count}, 32'h4);
        chk("ovf_full_after_drop", {31'h0, full}, 32'h1);
        gnt = 1'b1;
        wait_idle("ovf");
        chk("ovf_empty", {31'h0, empty}, 32'h1);

        // Write during the last DRIVE cycle keeps the tenure going.
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h33);
        wr(8'h11);
        step();
        step();
        chk("simul_s_first", {31'h0, s}, 32'h1);
        chk("simul_count_first", {29'h0, count}, 32'h1);
        wr(8'h33);
        chk("simul_count_kept", {29'h0, count}, 32'h1);
        chk("simul_s_kept", {31'h0, s}, 32'h1);
        chk("simul_data", {24'h0, bus_data}, 32'h33);
        wait_idle("simul");

        // Asynchronous reset while driving.
        exp_q.push_back(8'h77);
        exp_q.push_back(8'h78);
        exp_q.push_back(8'h79);
        wr(8'h77);
        wr(8'h78);
        wr(8'h79);
        for (int i = 0; i < 10 && !s; i++) step();
        chk("arst_s_before", {31'h0, s}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_s", {31'h0, s}, 32'h0);
        chk("arst_req", {31'h0, req}, 32'h0);
        chk("arst_count", {29'h0, count}, 32'h0);
        chk("arst_empty", {31'h0, empty}, 32'h1);
        chk("arst_bus_data", {24'h0, bus_data}, 32'h0);
        exp_q.delete();
        #3 rst_n = 1'b1;
        repeat (10) step();
        chk("arst_post_s", {31'h0, s}, 32'h0);
        chk("arst_post_req", {31'h0, req}, 32'h0);
        chk("arst_post_empty", {31'h0, empty}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
